// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared period counter, per-channel duty set by
// debounced inc/dec buttons or a direct load, double-buffered at the period wrap.
module pwm_multi_gen #(
   parameter int unsigned CH        = 2,
   parameter int unsigned CW        = 8,
   parameter int unsigned DEB_DIV   = 4,
   parameter int unsigned STEP      = 1,
   parameter int unsigned DUTY_INIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CW-1:0]    period,
   input  logic [CH-1:0]    btn_inc,
   input  logic [CH-1:0]    btn_dec,
   input  logic             ld_valid,
   input  logic [2:0]       ld_ch,
   input  logic [CW-1:0]    ld_duty,
   output logic [CH-1:0]    pwm_out,
   output logic [CH*CW-1:0] duty_act,
   output logic             period_tick
);

   localparam int unsigned PW    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam logic [CW:0] MAXV  = {1'b0, {CW{1'b1}}};
   localparam logic [CW:0] STEPW = (CW+1)'(STEP);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_period_act;
   logic          r_tick;
   logic [CH-1:0] r_pwm;
   logic [CW-1:0] r_duty_act [CH];
   logic [CW-1:0] r_duty_sh  [CH];

   logic [PW-1:0] r_presc;
   logic [CH-1:0] r_inc_s1, r_inc_s2, r_inc_d1, r_inc_d2;
   logic [CH-1:0] r_dec_s1, r_dec_s2, r_dec_d1, r_dec_d2;

   logic          w_tick;
   logic [CH-1:0] w_inc_ev, w_dec_ev;
   logic [CW:0]   w_sum    [CH];
   logic [CW-1:0] w_up     [CH];
   logic [CW-1:0] w_dn     [CH];
   logic [CW-1:0] w_sh_nxt [CH];

   // Period counter; active period/duty reload at the wrap, or continuously while stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_period_act <= '0;
         r_tick       <= 1'b0;
         r_pwm        <= '0;
         for (int unsigned i = 0; i < CH; i++) r_duty_act[i] <= CW'(DUTY_INIT);
      end else begin
         if (!en || r_cnt == r_period_act) begin
            r_cnt        <= '0;
            r_tick       <= en;
            r_period_act <= period;
            for (int unsigned i = 0; i < CH; i++) r_duty_act[i] <= r_duty_sh[i];
         end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
         end
         for (int unsigned i = 0; i < CH; i++)
            r_pwm[i] <= en & (r_cnt < r_duty_act[i]);
      end
   end

   assign w_tick   = (r_presc == PW'(DEB_DIV - 1));
   assign w_inc_ev = {CH{w_tick}} & r_inc_d1 & ~r_inc_d2;
   assign w_dec_ev = {CH{w_tick}} & r_dec_d1 & ~r_dec_d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc  <= '0;
         r_inc_s1 <= '0;
         r_inc_s2 <= '0;
         r_inc_d1 <= '0;
         r_inc_d2 <= '0;
         r_dec_s1 <= '0;
         r_dec_s2 <= '0;
         r_dec_d1 <= '0;
         r_dec_d2 <= '0;
      end else begin
         r_presc  <= w_tick ? '0 : r_presc + PW'(1);
         r_inc_s1 <= btn_inc;
         r_inc_s2 <= r_inc_s1;
         r_dec_s1 <= btn_dec;
         r_dec_s2 <= r_dec_s1;
         if (w_tick) begin
            r_inc_d1 <= r_inc_s2;
            r_inc_d2 <= r_inc_d1;
            r_dec_d1 <= r_dec_s2;
            r_dec_d2 <= r_dec_d1;
         end
      end
   end

   // Saturating step computed one bit wider so it can never wrap
   always_comb begin
      for (int unsigned i = 0; i < CH; i++) begin
         w_sum[i]    = {1'b0, r_duty_sh[i]} + STEPW;
         w_up[i]     = (w_sum[i] > MAXV) ? {CW{1'b1}} : w_sum[i][CW-1:0];
         w_dn[i]     = ({1'b0, r_duty_sh[i]} < STEPW) ? '0 : r_duty_sh[i] - STEPW[CW-1:0];
         w_sh_nxt[i] = r_duty_sh[i];
         if (ld_valid && ld_ch == 3'(i))
            w_sh_nxt[i] = ld_duty;
         else if (w_inc_ev[i] && w_dec_ev[i])
            w_sh_nxt[i] = r_duty_sh[i];
         else if (w_inc_ev[i])
            w_sh_nxt[i] = w_up[i];
         else if (w_dec_ev[i])
            w_sh_nxt[i] = w_dn[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH; i++) r_duty_sh[i] <= CW'(DUTY_INIT);
      end else begin
         for (int unsigned i = 0; i < CH; i++) r_duty_sh[i] <= w_sh_nxt[i];
      end
   end

   always_comb begin
      duty_act = '0;
      for (int unsigned i = 0; i < CH; i++) duty_act[i*CW +: CW] = r_duty_act[i];
   end

   assign pwm_out     = r_pwm;
   assign period_tick = r_tick;

endmodule
